// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM.
// Holds the state encoding, the supported opcodes, the ALUop codes handed
// to the ALU control decoder, and the packed control word produced by
// mc_ctrl_decode and gated by multi_cycle_ctrl.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // Raw per-state control word, before reset and mem_ready gating.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memtoreg;
    logic       regdst;
    logic       reg_write;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the main FSM and the multi-cycle datapath.
// master: the controller (reads Op/mem_ready, drives every enable/select).
// slave : the datapath/memory side (drives Op/mem_ready, reads controls).
// state is a debug view of the controller's current state.
interface multi_cycle_ctrl_if #(parameter int OPW = 6);
  logic [OPW-1:0] Op;
  logic           mem_ready;
  logic           PCWrite;
  logic           PCWriteCond;
  logic           IorD;
  logic           MemRead;
  logic           MemWrite;
  logic           IRWrite;
  logic           MemtoReg;
  logic           RegDst;
  logic           RegWrite;
  logic           ALUSrcA;
  logic [1:0]     ALUSrcB;
  logic [1:0]     ALUop;
  logic [1:0]     PCSource;
  logic           instr_done;
  logic           illegal_op;
  logic [3:0]     state;

  modport master (
    input  Op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource,
           instr_done, illegal_op, state
  );

  modport slave (
    output Op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource,
           instr_done, illegal_op, state
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control-word decoder for the main control FSM.
// Ports: state (current FSM state) -> ctrl (raw Moore control word).
// mem_ready and reset gating are applied by the caller.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = 1'b1;
        ctrl.pc_write = 1'b1;
        ctrl.alusrcb  = 2'b01;
        ctrl.aluop    = ALUOP_ADD;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut.
        ctrl.alusrcb = 2'b11;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b00;
        ctrl.aluop   = ALUOP_FUNC;
      end
      S_RTYPE_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.regdst     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca       = 1'b1;
        ctrl.alusrcb       = 2'b00;
        ctrl.aluop         = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pcsource      = 2'b01;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pcsource   = 2'b10;
        ctrl.instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Ports: clk, rst_n (synchronous, active-low), bus (master modport):
//   Op/mem_ready in; PC/memory/IR/register-file enables, mux selects,
//   ALUop, instr_done, illegal_op and the debug state out.
// Holds the state register and next-state logic; per-state controls come
// from mc_ctrl_decode and are gated here by mem_ready and reset.
module multi_cycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input logic                clk,
  input logic                rst_n,
  multi_cycle_ctrl_if.master bus
);

  state_t         state_q, state_d;
  ctrl_t          raw, gated;
  logic           illegal;
  logic [OPW-1:0] op;
  logic           mr;

  assign op = bus.Op;
  assign mr = bus.mem_ready;

  mc_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (raw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mr ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      // The IR is held stable after fetch, so Op still selects LW vs SW here.
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = mr ? S_MEMWB : S_MEMRD;
      S_MEMWR:    state_d = mr ? S_FETCH : S_MEMWR;
      S_EXEC:     state_d = S_RTYPE_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    gated   = raw;
    illegal = 1'b0;
    // IR and PC only load on the cycle the fetch actually completes.
    if (state_q == S_FETCH) begin
      gated.ir_write = raw.ir_write & mr;
      gated.pc_write = raw.pc_write & mr;
    end
    // MemWrite stays up through the wait; the store retires on mem_ready.
    if (state_q == S_MEMWR) gated.instr_done = raw.instr_done & mr;
    if (state_q == S_DECODE && !op_legal(op)) begin
      illegal          = 1'b1;
      gated.instr_done = 1'b1;
    end
    // Reset suppresses every strobe, aborting any in-flight write-back.
    if (!rst_n) begin
      gated   = '0;
      illegal = 1'b0;
    end
  end

  assign bus.PCWrite     = gated.pc_write;
  assign bus.PCWriteCond = gated.pc_write_cond;
  assign bus.IorD        = gated.iord;
  assign bus.MemRead     = gated.mem_read;
  assign bus.MemWrite    = gated.mem_write;
  assign bus.IRWrite     = gated.ir_write;
  assign bus.MemtoReg    = gated.memtoreg;
  assign bus.RegDst      = gated.regdst;
  assign bus.RegWrite    = gated.reg_write;
  assign bus.ALUSrcA     = gated.alusrca;
  assign bus.ALUSrcB     = gated.alusrcb;
  assign bus.ALUop       = gated.aluop;
  assign bus.PCSource    = gated.pcsource;
  assign bus.instr_done  = gated.instr_done;
  assign bus.illegal_op  = illegal;
  assign bus.state       = rst_n ? state_q : S_FETCH;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Testbench for multi_cycle_ctrl: directed vector tables, hand-written
// reset sequences, and a randomized run against an instruction-level model.
module tb_multi_cycle_ctrl;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multi_cycle_ctrl_if #(.OPW(6)) bus ();

  multi_cycle_ctrl #(.OPW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Control signature: {ill,irw,pcw,pcwc,rw,mw,mrd, ALUop, ALUSrcB, PCSource}
  function automatic logic [12:0] obs();
    return {bus.illegal_op, bus.IRWrite, bus.PCWrite, bus.PCWriteCond,
            bus.RegWrite, bus.MemWrite, bus.MemRead,
            bus.ALUop, bus.ALUSrcB, bus.PCSource};
  endfunction

  function automatic logic [21:0] all_out();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUop, bus.PCSource, bus.instr_done,
            bus.illegal_op, bus.state};
  endfunction

  localparam logic [12:0] C_FE  = {7'b0110001, 2'b00, 2'b01, 2'b00};
  localparam logic [12:0] C_FEW = {7'b0000001, 2'b00, 2'b01, 2'b00};
  localparam logic [12:0] C_DE  = {7'b0000000, 2'b00, 2'b11, 2'b00};
  localparam logic [12:0] C_DEI = {7'b1000000, 2'b00, 2'b11, 2'b00};
  localparam logic [12:0] C_MA  = {7'b0000000, 2'b00, 2'b10, 2'b00};
  localparam logic [12:0] C_MR  = {7'b0000001, 2'b00, 2'b00, 2'b00};
  localparam logic [12:0] C_WB  = {7'b0000100, 2'b00, 2'b00, 2'b00};
  localparam logic [12:0] C_MW  = {7'b0000010, 2'b00, 2'b00, 2'b00};
  localparam logic [12:0] C_EX  = {7'b0000000, 2'b10, 2'b00, 2'b00};
  localparam logic [12:0] C_BR  = {7'b0001000, 2'b01, 2'b00, 2'b01};
  localparam logic [12:0] C_J   = {7'b0010000, 2'b00, 2'b00, 2'b10};
  localparam logic [12:0] C_AE  = {7'b0000000, 2'b00, 2'b10, 2'b00};

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic        done;
    logic [12:0] ctl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [5:0] op, logic mr, logic [3:0] st,
                              logic done, logic [12:0] ctl);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.done = done; v.ctl = ctl;
    return v;
  endfunction

  // Instruction-level reference: the list of steps an opcode walks through.
  function automatic void build_steps(input logic [5:0] op, ref int q[$]);
    q = {0, 1};
    case (op)
      OP_LW:   q = {0, 1, 2, 3, 4};
      OP_SW:   q = {0, 1, 2, 5};
      OP_R:    q = {0, 1, 6, 7};
      OP_ADDI: q = {0, 1, 10, 11};
      OP_BEQ:  q = {0, 1, 8};
      OP_J:    q = {0, 1, 9};
      default: q = {0, 1};
    endcase
  endfunction

  // Expected {done, ill, irw, pcw, rw, mw, mrd} for a step.
  function automatic logic [6:0] ref_sig(int step, logic mr, logic legal);
    logic done, ill, irw, pcw, rw, mw, mrd;
    ill  = (step == 1) && !legal;
    done = (step inside {4, 7, 8, 9, 11}) || (step == 5 && mr) || ill;
    irw  = (step == 0) && mr;
    pcw  = ((step == 0) && mr) || (step == 9);
    rw   = step inside {4, 7, 11};
    mw   = (step == 5);
    mrd  = step inside {0, 3};
    return {done, ill, irw, pcw, rw, mw, mrd};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int q[$];
    logic [5:0] cur_op;
    logic [5:0] legal_ops [6];
    legal_ops = '{OP_LW, OP_SW, OP_R, OP_ADDI, OP_BEQ, OP_J};

    // All six legal opcodes back-to-back, mem_ready tied high.
    tbl.push_back(mk(OP_LW,   1, 0,  0, C_FE));
    tbl.push_back(mk(OP_LW,   1, 1,  0, C_DE));
    tbl.push_back(mk(OP_LW,   1, 2,  0, C_MA));
    tbl.push_back(mk(OP_LW,   1, 3,  0, C_MR));
    tbl.push_back(mk(OP_LW,   1, 4,  1, C_WB));
    tbl.push_back(mk(OP_SW,   1, 0,  0, C_FE));
    tbl.push_back(mk(OP_SW,   1, 1,  0, C_DE));
    tbl.push_back(mk(OP_SW,   1, 2,  0, C_MA));
    tbl.push_back(mk(OP_SW,   1, 5,  1, C_MW));
    tbl.push_back(mk(OP_R,    1, 0,  0, C_FE));
    tbl.push_back(mk(OP_R,    1, 1,  0, C_DE));
    tbl.push_back(mk(OP_R,    1, 6,  0, C_EX));
    tbl.push_back(mk(OP_R,    1, 7,  1, C_WB));
    tbl.push_back(mk(OP_ADDI, 1, 0,  0, C_FE));
    tbl.push_back(mk(OP_ADDI, 1, 1,  0, C_DE));
    tbl.push_back(mk(OP_ADDI, 1, 10, 0, C_AE));
    tbl.push_back(mk(OP_ADDI, 1, 11, 1, C_WB));
    tbl.push_back(mk(OP_BEQ,  1, 0,  0, C_FE));
    tbl.push_back(mk(OP_BEQ,  1, 1,  0, C_DE));
    tbl.push_back(mk(OP_BEQ,  1, 8,  1, C_BR));
    tbl.push_back(mk(OP_J,    1, 0,  0, C_FE));
    tbl.push_back(mk(OP_J,    1, 1,  0, C_DE));
    tbl.push_back(mk(OP_J,    1, 9,  1, C_J));
    // LW with 2 wait cycles in FETCH and 3 in MEMRD.
    tbl.push_back(mk(OP_LW,   0, 0,  0, C_FEW));
    tbl.push_back(mk(OP_LW,   0, 0,  0, C_FEW));
    tbl.push_back(mk(OP_LW,   1, 0,  0, C_FE));
    tbl.push_back(mk(OP_LW,   1, 1,  0, C_DE));
    tbl.push_back(mk(OP_LW,   1, 2,  0, C_MA));
    tbl.push_back(mk(OP_LW,   0, 3,  0, C_MR));
    tbl.push_back(mk(OP_LW,   0, 3,  0, C_MR));
    tbl.push_back(mk(OP_LW,   0, 3,  0, C_MR));
    tbl.push_back(mk(OP_LW,   1, 3,  0, C_MR));
    tbl.push_back(mk(OP_LW,   1, 4,  1, C_WB));
    // Two illegal opcodes in a row.
    tbl.push_back(mk(6'h3f,   1, 0,  0, C_FE));
    tbl.push_back(mk(6'h3f,   1, 1,  1, C_DEI));
    tbl.push_back(mk(6'h3f,   1, 0,  0, C_FE));
    tbl.push_back(mk(6'h3f,   1, 1,  1, C_DEI));

    // Reset held for three cycles.
    rst_n = 1'b0;
    bus.Op = OP_LW;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("reset_outputs[%0d]", i), 32'(all_out()), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    dones = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      bus.Op = tbl[i].op;
      bus.mem_ready = tbl[i].mr;
      #1;
      chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_done", i), 32'(bus.instr_done), 32'(tbl[i].done));
      chk($sformatf("vec%0d_ctl", i), 32'(obs()), 32'(tbl[i].ctl));
      if (i < 23 && bus.instr_done) dones++;
      if (i == 22) chk("done_pulses_23_cycles", 32'(dones), 32'd6);
      @(negedge clk);
    end

    // Reset dropped while a store is waiting on memory.
    bus.Op = OP_SW;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("sw_wait_state", 32'(bus.state), 32'(S_MEMWR));
    chk("sw_wait_memwrite", 32'(bus.MemWrite), 32'd1);
    chk("sw_wait_done", 32'(bus.instr_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("sw_reset_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("sw_reset_outputs", 32'(all_out()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    chk("sw_reset_state", 32'(bus.state), 32'(S_FETCH));
    chk("sw_reset_fetch_ctl", 32'(obs()), 32'(C_FE));

    // Randomized instruction stream against the step-list model.
    q.delete();
    cur_op = OP_LW;
    for (int c = 0; c < 600; c++) begin
      int step;
      logic mr;
      logic legal;
      if (q.size() == 0) begin
        if ($urandom_range(0, 7) < 6) cur_op = legal_ops[$urandom_range(0, 5)];
        else cur_op = 6'($urandom_range(0, 63));
        build_steps(cur_op, q);
      end
      mr = ($urandom_range(0, 3) != 0);
      bus.Op = cur_op;
      bus.mem_ready = mr;
      step = q[0];
      legal = 1'b0;
      foreach (legal_ops[k]) if (legal_ops[k] == cur_op) legal = 1'b1;
      #1;
      chk($sformatf("rnd%0d_state", c), 32'(bus.state), 32'(step));
      chk($sformatf("rnd%0d_sig", c),
          32'({bus.instr_done, bus.illegal_op, bus.IRWrite, bus.PCWrite,
               bus.RegWrite, bus.MemWrite, bus.MemRead}),
          32'(ref_sig(step, mr, legal)));
      if (!((step == 0 || step == 3 || step == 5) && !mr)) void'(q.pop_front());
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
